// File: rtl/handshake_tx.sv
// handshake_tx: sends WIDTH-bit words out of the clk domain over a 4-phase
// req/ack handshake. The returning acknowledge is resynchronised through a
// SYNC_STAGES flop chain. data_out is loaded only when a word is accepted and
// stays stable until the handshake completes.
// Optional feature macro: HANDSHAKE_TX_TIMEOUT_EN adds a per-phase abort
// counter and a sticky timeout_err flag. Without it timeout_err is always 0.
module handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_async,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACK_WAIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               req_out_reg, req_out_next;
    logic [WIDTH-1:0]   data_out_reg, data_out_next;
    logic               timeout_err_reg, timeout_err_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_in;
    logic                   ack_sync;

    // Each synchroniser stage takes the previous one; stage 0 takes the raw ack.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_in[gi] = ack_async;
            end else begin : g_rest
                assign sync_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Acknowledge synchroniser chain, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_in;
        end
    end

    assign ack_sync = sync_reg[SYNC_STAGES-1];

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_reg, count_next;
    logic             count_hit;

    // The counter value after this edge would reach TIMEOUT_CYCLES.
    assign count_hit = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Parameter kept for interface compatibility; it has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // A new word may only be taken in IDLE once the previous ack has fully dropped.
    assign in_ready    = (state_reg == IDLE) && !ack_sync;
    assign busy        = (state_reg != IDLE);
    assign req_out     = req_out_reg;
    assign data_out    = data_out_reg;
    assign timeout_err = timeout_err_reg;

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        state_next       = state_reg;
        req_out_next     = req_out_reg;
        data_out_next    = data_out_reg;
        timeout_err_next = timeout_err_reg;
        case (state_reg)
            IDLE: begin
                req_out_next = 1'b0;
                if (in_valid && in_ready) begin
                    data_out_next = in_data;
                    req_out_next  = 1'b1;
                    state_next    = REQ;
                end
            end
            REQ: begin
                // A falling ack_sync here is ignored: only its rise matters.
                req_out_next = 1'b1;
                if (ack_sync) begin
                    req_out_next = 1'b0;
                    state_next   = ACK_WAIT;
                end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
                else if (count_hit) begin
                    req_out_next     = 1'b0;
                    timeout_err_next = 1'b1;
                    state_next       = ACK_WAIT;
                end
`endif
            end
            ACK_WAIT: begin
                req_out_next = 1'b0;
                if (!ack_sync) begin
                    state_next = IDLE;
                end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
                else if (count_hit) begin
                    timeout_err_next = 1'b1;
                    state_next       = IDLE;
                end
`endif
            end
            default: begin
                req_out_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            req_out_reg     <= 1'b0;
            data_out_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_out_reg     <= req_out_next;
            data_out_reg    <= data_out_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

`ifdef HANDSHAKE_TX_TIMEOUT_EN
    // Phase counter: restarts on every state change, counts while handshaking.
    always_comb begin
        count_next = '0;
        if ((state_next == state_reg) && (state_reg != IDLE)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// tb_handshake_tx: directed bench for handshake_tx (WIDTH=8, SYNC_STAGES=2).
// The timeout scenario runs only when HANDSHAKE_TX_TIMEOUT_EN is defined.
module tb_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_async = 1'b0;
    logic       busy;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    handshake_tx #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .req_out(req_out),
        .data_out(data_out),
        .ack_async(ack_async),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete handshake. Receiver raises ack 2 cycles after req rises and
    // drops it 2 cycles after req falls. t counts edges after the accept edge.
    // Expected: req high t=1..5, falls at t=6; busy high t=1..10; ready at t=11.
    task automatic send_word(input logic [7:0] d, input logic keep_valid, input logic [7:0] next_d);
        check("pre_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 1; t <= 11; t++) begin
            step();
            check("hs_req",   32'(req_out),  32'(t <= 5));
            check("hs_busy",  32'(busy),     32'(t <= 10));
            check("hs_ready", 32'(in_ready), 32'(t == 11));
            check("hs_data",  32'(data_out), 32'(d));
            if (t == 1) begin
                if (keep_valid) in_data = next_d;
                else in_valid = 1'b0;
            end
            if (t == 3) ack_async = 1'b1;
            if (t == 8) ack_async = 1'b0;
        end
        $display("[TB] word %02h handshake complete, data_out=%02h", d, data_out);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset held 3 cycles.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_req",  32'(req_out),  32'd0);
            check("rst_data", 32'(data_out), 32'd0);
            check("rst_busy", 32'(busy),     32'd0);
        end
        rst_n = 1'b1;
        step();
        check("rel_ready", 32'(in_ready),    32'd1);
        check("rel_terr",  32'(timeout_err), 32'd0);
        $display("[TB] reset released, in_ready=%0d", in_ready);

        // 2. Single word A5.
        send_word(8'hA5, 1'b0, 8'h00);

        // 3. Back-to-back 01, 02, 03; in_valid kept high with the next word.
        send_word(8'h01, 1'b1, 8'h02);
        send_word(8'h02, 1'b1, 8'h03);
        send_word(8'h03, 1'b0, 8'h00);

        // 4. Stale ack at reset release: ack high for edges R0..R4.
        rst_n = 1'b0;
        ack_async = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        for (int r = 0; r <= 6; r++) begin
            step();
            if (r >= 1) check("stale_ready", 32'(in_ready), 32'(r == 6));
            check("stale_req", 32'(req_out), 32'd0);
            if (r == 1) begin
                in_valid = 1'b1;
                in_data  = 8'h5A;
            end
            if (r == 4) ack_async = 1'b0;
            if (r == 6) in_valid = 1'b0;
        end
        check("stale_busy", 32'(busy), 32'd0);
        $display("[TB] stale ack drained, in_ready=%0d req_out=%0d", in_ready, req_out);

        // 5. Reset during REQ with ack pending.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        in_valid = 1'b0;
        check("r5_req",  32'(req_out),  32'd1);
        check("r5_data", 32'(data_out), 32'h3C);
        ack_async = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        check("r5_req_drop", 32'(req_out),  32'd0);
        check("r5_data_clr", 32'(data_out), 32'd0);
        check("r5_idle",     32'(busy),     32'd0);
        ack_async = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("r5_ready", 32'(in_ready), 32'd1);
        $display("[TB] reset mid-handshake, req_out=%0d busy=%0d", req_out, busy);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
        // 6. Ack never rises: abort 16 cycles after entering REQ.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        step();
        in_valid = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            step();
            check("to_req",  32'(req_out),     32'(t <= 15));
            check("to_busy", 32'(busy),        32'(t <= 16));
            check("to_terr", 32'(timeout_err), 32'(t >= 16));
            check("to_data", 32'(data_out),    32'hC3);
        end
        $display("[TB] timeout abort, timeout_err=%0d", timeout_err);
        send_word(8'h77, 1'b0, 8'h00);
        check("to_sticky", 32'(timeout_err), 32'd1);
`else
        check("terr_off", 32'(timeout_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
